// File: rtl/dm_stream_loader_pkg.sv
// Shared constants for the data-memory stream loader:
// sync/command bytes, status codes and frame FSM states.
package dm_stream_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_CSUM  = 8'hE1;
    localparam logic [7:0] ST_RANGE = 8'hE2;
    localparam logic [7:0] ST_CMD   = 8'hE3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_t;

endpackage

// File: rtl/dm_loader_frame_fsm.sv
// Frame parser: state register, field capture, range and checksum checks.
// Ports: in_* host byte stream, out_* status stream, wr_* write request
// (same cycle as the accepted data byte), hold_set/hold_clr CPU hold pulses.
// Optional checksum verification under `DM_LOADER_CSUM_EN.
module dm_loader_frame_fsm #(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              hold_set,
    output logic              hold_clr
);
    import dm_stream_loader_pkg::*;

    state_t state;
    state_t state_nx;

    logic [7:0]        addr_h;
    logic [7:0]        len_h;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cnt;
    logic              range_bad;
    logic [7:0]        status;
    logic              acc;
    logic              last;
    logic              over;
    logic              csum_bad;
    logic [ADDR_W-1:0] len_new;
    logic [ADDR_W:0]   end_addr;

    assign in_ready = (state != S_RESP);
    assign acc      = in_valid && in_ready;
    assign len_new  = ADDR_W'({len_h, in_data});
    // one extra bit so addr+len never wraps before the compare
    assign end_addr = {1'b0, addr} + {1'b0, len_new};
    assign over     = end_addr > (ADDR_W+1)'(MEM_SIZE);
    assign last     = (cnt == len - ADDR_W'(1));
    assign out_data = status;
    assign wr_addr  = addr + cnt;
    assign wr_data  = in_data;

`ifdef DM_LOADER_CSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= 8'h00;
        end else if (acc && state == S_CMD) begin
            sum <= 8'h00;
        end else if (acc && state == S_DATA) begin
            sum <= sum + in_data;
        end
    end

    assign csum_bad = (in_data != sum);
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (acc && in_data == SYNC_BYTE) state_nx = S_CMD;
            S_CMD:    if (acc) state_nx = (in_data == CMD_WRITE) ? S_ADDR_H : S_RESP;
            S_ADDR_H: if (acc) state_nx = S_ADDR_L;
            S_ADDR_L: if (acc) state_nx = S_LEN_H;
            S_LEN_H:  if (acc) state_nx = S_LEN_L;
            S_LEN_L:  if (acc) state_nx = (len_new == '0) ? S_CSUM : S_DATA;
            S_DATA:   if (acc && last) state_nx = S_CSUM;
            S_CSUM:   if (acc) state_nx = S_RESP;
            S_RESP:   if (out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == S_RESP);
        wr_en     = acc && (state == S_DATA) && !range_bad;
        hold_set  = acc && (state == S_CMD) && (in_data == CMD_WRITE);
        hold_clr  = acc && (state == S_CMD) && (in_data == CMD_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_h    <= 8'h00;
            len_h     <= 8'h00;
            addr      <= '0;
            len       <= '0;
            cnt       <= '0;
            range_bad <= 1'b0;
            status    <= ST_OK;
        end else if (acc) begin
            unique case (state)
                S_CMD: begin
                    cnt       <= '0;
                    range_bad <= 1'b0;
                    status    <= (in_data == CMD_WRITE || in_data == CMD_RUN)
                                 ? ST_OK : ST_CMD;
                end
                S_ADDR_H: addr_h <= in_data;
                S_ADDR_L: addr   <= ADDR_W'({addr_h, in_data});
                S_LEN_H:  len_h  <= in_data;
                S_LEN_L: begin
                    len       <= len_new;
                    range_bad <= over;
                end
                S_DATA: cnt <= cnt + ADDR_W'(1);
                S_CSUM: begin
                    // range failure outranks a checksum mismatch
                    if (range_bad)     status <= ST_RANGE;
                    else if (csum_bad) status <= ST_CSUM;
                    else               status <= ST_OK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dm_stream_loader.sv
// Data-memory loader: parses host frames, writes bytes into data memory,
// returns one status byte per frame and holds the CPU in reset until RUN.
// Ports: in_* host byte stream, out_* status stream, mem_* byte write port,
// cpu_hold CPU reset hold. Optional checksum check: `DM_LOADER_CSUM_EN.
module dm_stream_loader #(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold
);
    import dm_stream_loader_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              hold_set;
    logic              hold_clr;

    dm_loader_frame_fsm #(
        .MEM_SIZE (MEM_SIZE),
        .ADDR_W   (ADDR_W)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hold_set  (hold_set),
        .hold_clr  (hold_clr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            cpu_hold  <= 1'b1;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
            if (hold_set)      cpu_hold <= 1'b1;
            else if (hold_clr) cpu_hold <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_stream_loader.sv
// Directed testbench for dm_stream_loader: frame parsing, writes,
// status codes, backpressure, stalls and mid-frame reset.
module tb_dm_stream_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];

    dm_stream_loader #(
        .MEM_SIZE (1024),
        .ADDR_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$], input bit gap);
        foreach (q[i]) begin
            send(q[i]);
            if (gap) begin
                in_data = 8'h5C;
                @(negedge clk);
            end
        end
    endtask

    task automatic get_status(output logic [7:0] s);
        int n = 0;
        s = 8'hXX;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL status_timeout: out_valid=%0b required 1", out_valid);
        end else begin
            s = out_data;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_ready: got %0b want 1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid);
        end
        total++;
        if (out_data !== 8'h00) begin
            bad++; $display("FAIL rst_out_data: got %h want 00", out_data);
        end
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 8'h00) begin
            bad++;
            $display("FAIL rst_mem: got we=%0b a=%h d=%h want 0 0000 00",
                     mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL rst_cpu_hold: got %0b want 1", cpu_hold);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] q[$];
        logic [7:0] s;
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h03,
              8'h11, 8'h22, 8'h33, 8'h66};
        send_seq(q, 1'b0);
        get_status(s);
        total++;
        if (s !== 8'h00) begin
            bad++; $display("FAIL write_status: got %h want 00", s);
        end
        total++;
        if (wa_q.size() != 3) begin
            bad++; $display("FAIL write_count: got %0d want 3", wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 16'd16 || wd_q[0] !== 8'h11 ||
                wa_q[1] !== 16'd17 || wd_q[1] !== 8'h22 ||
                wa_q[2] !== 16'd18 || wd_q[2] !== 8'h33) begin
                bad++;
                $display("FAIL write_data: got %h@%0d %h@%0d %h@%0d want 11@16 22@17 33@18",
                         wd_q[0], wa_q[0], wd_q[1], wa_q[1], wd_q[2], wa_q[2]);
            end
            total++;
            if (wc_q[1] != wc_q[0] + 1 || wc_q[2] != wc_q[1] + 1) begin
                bad++;
                $display("FAIL write_consec: got cycles %0d %0d %0d want consecutive",
                         wc_q[0], wc_q[1], wc_q[2]);
            end
        end
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL write_hold: got %0b want 1", cpu_hold);
        end
    endtask

    task automatic test_run(input logic exp_hold_before);
        logic [7:0] s;
        send(8'hA5);
        in_data  = 8'h02;
        in_valid = 1'b1;
        total++;
        if (cpu_hold !== exp_hold_before) begin
            bad++;
            $display("FAIL run_hold_before: got %0b want %0b", cpu_hold, exp_hold_before);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (cpu_hold !== 1'b0) begin
            bad++; $display("FAIL run_hold_after: got %0b want 0", cpu_hold);
        end
        get_status(s);
        total++;
        if (s !== 8'h00) begin
            bad++; $display("FAIL run_status: got %h want 00", s);
        end
    endtask

    task automatic test_range();
        logic [7:0] q[$];
        logic [7:0] s;
        clear_log();
        q = '{8'hA5, 8'h01, 8'h03, 8'hFE, 8'h00, 8'h04,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        send_seq(q, 1'b0);
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL range_hold: got %0b want 1", cpu_hold);
        end
        get_status(s);
        total++;
        if (s !== 8'hE2) begin
            bad++; $display("FAIL range_status: got %h want E2", s);
        end
        total++;
        if (wa_q.size() != 0) begin
            bad++; $display("FAIL range_nowrite: got %0d writes want 0", wa_q.size());
        end
    endtask

    task automatic test_csum();
        logic [7:0] q[$];
        logic [7:0] s;
        logic [7:0] exp_s;
`ifdef DM_LOADER_CSUM_EN
        exp_s = 8'hE1;
`else
        exp_s = 8'h00;
`endif
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
              8'h01, 8'h02, 8'hFF};
        send_seq(q, 1'b0);
        get_status(s);
        total++;
        if (s !== exp_s) begin
            bad++; $display("FAIL csum_status: got %h want %h", s, exp_s);
        end
        total++;
        if (wa_q.size() != 2) begin
            bad++; $display("FAIL csum_count: got %0d want 2", wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 16'd0 || wd_q[0] !== 8'h01 ||
                wa_q[1] !== 16'd1 || wd_q[1] !== 8'h02) begin
                bad++;
                $display("FAIL csum_data: got %h@%0d %h@%0d want 01@0 02@1",
                         wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
            end
        end
    endtask

    task automatic test_bad_cmd_backpressure();
        logic [7:0] q[$];
        logic [7:0] s;
        int n = 0;
        q = '{8'h00, 8'hFF, 8'hA5, 8'h07};
        send_seq(q, 1'b0);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'hE3) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%0b rdy=%0b d=%h want 1 0 E3",
                         i, out_valid, in_ready, out_data);
            end
            @(negedge clk);
        end
        get_status(s);
        total++;
        if (s !== 8'hE3) begin
            bad++; $display("FAIL bp_status: got %h want E3", s);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_gappy_len0();
        logic [7:0] q[$];
        logic [7:0] s;
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        send_seq(q, 1'b1);
        get_status(s);
        total++;
        if (s !== 8'h00) begin
            bad++; $display("FAIL len0_status: got %h want 00", s);
        end
        total++;
        if (wa_q.size() != 0) begin
            bad++; $display("FAIL len0_nowrite: got %0d writes want 0", wa_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        logic [7:0] s;
        bit         seen = 1'b0;
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h00, 8'h05, 8'hAA, 8'hBB};
        send_seq(q, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL rmid_nostatus: got out_valid=1 want 0");
        end
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL rmid_hold: got %0b want 1", cpu_hold);
        end
        total++;
        if (wa_q.size() != 2) begin
            bad++; $display("FAIL rmid_count: got %0d want 2", wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 16'd64 || wd_q[0] !== 8'hAA ||
                wa_q[1] !== 16'd65 || wd_q[1] !== 8'hBB) begin
                bad++;
                $display("FAIL rmid_data: got %h@%0d %h@%0d want AA@64 BB@65",
                         wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
            end
        end
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'h50, 8'h00, 8'h01, 8'h5A, 8'h5A};
        send_seq(q, 1'b0);
        get_status(s);
        total++;
        if (s !== 8'h00) begin
            bad++; $display("FAIL rmid_next_status: got %h want 00", s);
        end
        total++;
        if (wa_q.size() != 1) begin
            bad++; $display("FAIL rmid_next_count: got %0d want 1", wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 16'd80 || wd_q[0] !== 8'h5A) begin
                bad++;
                $display("FAIL rmid_next_data: got %h@%0d want 5A@80", wd_q[0], wa_q[0]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_run(1'b1);
        test_range();
        test_run(1'b1);
        test_run(1'b0);
        test_csum();
        test_bad_cmd_backpressure();
        test_gappy_len0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
